// File: rtl/route_unit_pipe.sv
// rtl/route_unit_pipe.sv - registered N-channel mux/demux/priority-encoder/decoder with valid/ready handshake
module route_unit_pipe #(
  parameter int SEL_W = 2,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [(1<<SEL_W)-1:0]  data_in,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   scan_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [(1<<SEL_W)-1:0]  data_out,
  output logic                   enc_valid,
  output logic [SEL_W-1:0]       scan_idx,
  output logic [CNT_W-1:0]       xfer_cnt
);

  localparam int N = 1 << SEL_W;

  localparam logic [1:0] MODE_MUX   = 2'b00;
  localparam logic [1:0] MODE_DEMUX = 2'b01;
  localparam logic [1:0] MODE_PENC  = 2'b10;
  localparam logic [1:0] MODE_DEC   = 2'b11;

  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     data_out_q, data_out_d;
  logic             enc_valid_q, enc_valid_d;
  logic [SEL_W-1:0] scan_idx_q, scan_idx_d;
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

  logic             accept;
  logic [SEL_W-1:0] eff_sel;
  logic [N-1:0]     result;
  logic             result_enc;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign eff_sel  = scan_en ? scan_idx_q : sel;

  always_comb begin
    result     = '0;
    result_enc = 1'b0;
    case (mode)
      MODE_MUX:   result[0] = data_in[eff_sel];
      MODE_DEMUX: result[eff_sel] = data_in[0];
      MODE_PENC: begin
        // ascending scan so the highest set bit wins
        for (int i = 0; i < N; i++) begin
          if (data_in[i]) result[SEL_W-1:0] = SEL_W'(i);
        end
        result_enc = |data_in;
      end
      MODE_DEC:   result[data_in[SEL_W-1:0]] = 1'b1;
      default:    result = '0;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    enc_valid_d = enc_valid_q;
    scan_idx_d  = scan_idx_q;
    xfer_cnt_d  = xfer_cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      data_out_d  = result;
      enc_valid_d = result_enc;
      xfer_cnt_d  = xfer_cnt_q + CNT_W'(1);
      // N is a power of two, so natural overflow gives the N-1 -> 0 wrap
      if (scan_en) scan_idx_d = scan_idx_q + SEL_W'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      enc_valid_q <= 1'b0;
      scan_idx_q  <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      enc_valid_q <= enc_valid_d;
      scan_idx_q  <= scan_idx_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign enc_valid = enc_valid_q;
  assign scan_idx  = scan_idx_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: doc/route_unit_pipe.md
Name: route_unit_pipe

Overview:
Parametrised, registered routing/coding unit that generalises the fixed 4-way mux, demux, encoder and decoder into one N-channel block. Operation is chosen per transfer by a mode field. Operands are accepted through a valid/ready handshake and produce one registered result. An optional scan mode auto-steps the select index on every accepted transfer. The block sits between the stimulus/control logic and downstream consumers in the top-level datapath.

Parameters:
SEL_W, 2, select/index width; channel count N = 2**SEL_W (legal 1..5)
CNT_W, 8, width of the accepted-transfer counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
mode  input  2  operation: 00 mux, 01 demux, 10 priority encoder, 11 decoder
in_valid  input  1  operand present on data_in/sel/mode
in_ready  output  1  block can accept an operand this cycle
data_in  input  N  operand vector
sel  input  SEL_W  external select; used when scan_en=0
scan_en  input  1  1 = use internal scan index instead of sel
out_valid  output  1  data_out/enc_valid hold a result
out_ready  input  1  consumer takes the result this cycle
data_out  output  N  registered result
enc_valid  output  1  encoder mode only: 1 if any data_in bit was set
scan_idx  output  SEL_W  current internal scan index
xfer_cnt  output  CNT_W  count of accepted transfers, wraps

Behaviour:
- Reset (async, active-high): out_valid=0, data_out=0, enc_valid=0, scan_idx=0, xfer_cnt=0. A result pending when reset asserts is dropped. in_ready=1 once reset deasserts.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready.
  - The result is registered on the accepting edge, so latency is 1 cycle. out_valid=1 the next cycle.
  - out_valid stays 1 and data_out stays stable until out_ready=1.
  - Accept and drain in the same cycle give back-to-back throughput of one result per cycle.
  - If out_ready=1 with no accept, out_valid goes to 0 on the next edge and data_out holds its last value.
- Effective index s = scan_en ? scan_idx : sel, sampled on the accepting edge together with mode and data_in.
- Per mode, all bits of data_out not listed are 0:
  - mux: data_out[0] = data_in[s].
  - demux: data_out[s] = data_in[0].
  - priority encoder: data_out[SEL_W-1:0] = index of the highest set bit of data_in, with enc_valid=1. If data_in==0, then data_out=0 and enc_valid=0.
  - decoder: data_out = one-hot of data_in[SEL_W-1:0].
- enc_valid is 0 in every mode other than the priority encoder.
- Scan index:
  - Increments on each accepted transfer while scan_en=1, wrapping from N-1 to 0.
  - Holds while scan_en=0 or when there is no accept.
  - The accepting transfer uses the pre-increment value.
- xfer_cnt increments on every accept in any mode and wraps from 2**CNT_W-1 to 0.
- Mode or sel changes with no accept have no effect. Inputs are don't-care while in_valid=0.
- SEL_W=1 (N=2): same rules. The decoder uses data_in[0].

Test Plan:
1. Reset, then mode=00, data_in=4'b1001, sel=01, in_valid=1, out_ready=1 -> next cycle out_valid=1, data_out=4'b0000. Repeat with sel=11 -> data_out=4'b0001.
2. mode=01, data_in[0]=1, sel=10 -> data_out=4'b0100. mode=11, data_in=4'b0011 -> data_out=4'b1000.
3. mode=10, data_in=4'b0110 -> data_out=4'b0010, enc_valid=1. Then data_in=4'b0000 -> data_out=0, enc_valid=0.
4. Backpressure: out_ready=0 with two operands offered -> first result held stable, in_ready=0, second not accepted and xfer_cnt=1. Set out_ready=1 -> second accepted and appears on the next cycle, xfer_cnt=2.
5. Scan: scan_en=1, mode=00, data_in=4'b1010, five back-to-back accepts -> data_out[0] sequence 0,1,0,1,0 and scan_idx sequence 1,2,3,0,1 (wrap).
6. Assert reset while out_valid=1 and scan_idx=2 -> immediately out_valid=0, data_out=0, scan_idx=0, xfer_cnt=0, with no clock edge required.
